// File: rtl/s641_bist_pkg.sv
// Shared types, constants and the MISR update function for the s641 response compactor.
package s641_bist_pkg;

  localparam int S641_OUT_W = 24;
  localparam logic [S641_OUT_W-1:0] S641_MISR_POLY = 24'hC20001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Galois step: shift up, fold the outgoing MSB back through the feedback mask, absorb din.
  function automatic logic [S641_OUT_W-1:0] misr_next(
    input logic [S641_OUT_W-1:0] sig,
    input logic [S641_OUT_W-1:0] din,
    input logic [S641_OUT_W-1:0] poly
  );
    logic [S641_OUT_W-1:0] fb;
    fb = sig[S641_OUT_W-1] ? poly : '0;
    return {sig[S641_OUT_W-2:0], 1'b0} ^ fb ^ din;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register with synchronous reseed (load) and MISR absorb step (en); load has priority.
module misr_core
  import s641_bist_pkg::*;
#(
  parameter int                    WIDTH     = S641_OUT_W,
  parameter logic [WIDTH-1:0]      POLY      = S641_MISR_POLY,
  parameter logic [WIDTH-1:0]      RESET_SIG = '0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = seed;
    end else if (en) begin
      sig_d = misr_next(sig_q, din, POLY);
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      sig_q <= RESET_SIG;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/s641_misr_compactor.sv
// Folds WINDOW valid s641 output samples into a MISR signature and holds it in DONE.
// Optional golden-signature comparator (PASS output) enabled by S641_MISR_CMP_EN.
module s641_misr_compactor
  import s641_bist_pkg::*;
#(
  parameter int               WIDTH  = S641_OUT_W,
  parameter logic [WIDTH-1:0] POLY   = S641_MISR_POLY,
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter int               WINDOW = 256
`ifdef S641_MISR_CMP_EN
  ,
  parameter logic [WIDTH-1:0] GOLDEN = '0
`endif
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             START,
  input  logic             VALID,
  input  logic [WIDTH-1:0] DIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SIGNATURE,
`ifdef S641_MISR_CMP_EN
  output logic             PASS,
`endif
  output state_e           dbg_state_o
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);

  // Handshake: a sample is consumed on every rising edge where VALID=1 and BUSY=1;
  // VALID outside RUN is ignored, and START outside RUN takes priority over VALID.

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;
  logic             absorb;
  logic             last_take;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    absorb    = 1'b0;
    last_take = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (VALID) begin
          absorb = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            last_take = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  misr_core #(
    .WIDTH    (WIDTH),
    .POLY     (POLY),
    .RESET_SIG(SEED)
  ) u_misr (
    .CK  (CK),
    .RN  (RN),
    .load(load),
    .en  (absorb),
    .seed(SEED),
    .din (DIN),
    .sig (SIGNATURE)
  );

`ifdef S641_MISR_CMP_EN
  logic pass_q, pass_d;

  // Compare the value being written on the final sample, so PASS lines up with DONE.
  always_comb begin
    pass_d = pass_q;
    if (load) begin
      pass_d = 1'b0;
    end else if (last_take) begin
      pass_d = (misr_next(SIGNATURE, DIN, POLY) == GOLDEN);
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
    end
  end

  assign PASS = pass_q;
`endif

  assign BUSY        = (state_q == ST_RUN);
  assign DONE        = (state_q == ST_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_s641_misr_compactor.sv
// Randomised and directed bench for s641_misr_compactor with a polynomial-arithmetic reference model.
module tb_s641_misr_compactor;

  localparam int               W      = 24;
  localparam logic [W-1:0]     POLY_M = 24'hC20001;
  localparam logic [W-1:0]     SEED_A = 24'h000001;
  localparam int               WIN_A  = 4;
  localparam logic [W-1:0]     GOLD_A = 24'h000010;

  // ---------------- clock / reset ----------------
  logic CK = 1'b0;
  logic RN;
  always #5 CK = ~CK;

  // ---------------- main DUT (WINDOW=4, SEED=1) ----------------
  logic         start, valid;
  logic [W-1:0] din;
  logic         busy_a, done_a;
  logic [W-1:0] sig_a;
  logic [1:0]   dbg_a;
`ifdef S641_MISR_CMP_EN
  logic         pass_a;
`endif

  s641_misr_compactor #(
    .WINDOW(WIN_A),
    .SEED  (SEED_A)
`ifdef S641_MISR_CMP_EN
    ,
    .GOLDEN(GOLD_A)
`endif
  ) u_dut (
    .CK         (CK),
    .RN         (RN),
    .START      (start),
    .VALID      (valid),
    .DIN        (din),
    .BUSY       (busy_a),
    .DONE       (done_a),
    .SIGNATURE  (sig_a),
`ifdef S641_MISR_CMP_EN
    .PASS       (pass_a),
`endif
    .dbg_state_o(dbg_a)
  );

  // ---------------- single-sample instances (WINDOW=1) ----------------
  logic         s2_start, s2_valid;
  logic [W-1:0] s2_din;
  logic         busy_b, done_b, busy_c, done_c;
  logic [W-1:0] sig_b, sig_c;
  logic [1:0]   dbg_b, dbg_c;
`ifdef S641_MISR_CMP_EN
  logic         pass_b, pass_c;
`endif

  s641_misr_compactor #(.WINDOW(1), .SEED(24'h000000)) u_w1_s0 (
    .CK(CK), .RN(RN), .START(s2_start), .VALID(s2_valid), .DIN(s2_din),
    .BUSY(busy_b), .DONE(done_b), .SIGNATURE(sig_b),
`ifdef S641_MISR_CMP_EN
    .PASS(pass_b),
`endif
    .dbg_state_o(dbg_b)
  );

  s641_misr_compactor #(.WINDOW(1), .SEED(24'h800000)) u_w1_s8 (
    .CK(CK), .RN(RN), .START(s2_start), .VALID(s2_valid), .DIN(s2_din),
    .BUSY(busy_c), .DONE(done_c), .SIGNATURE(sig_c),
`ifdef S641_MISR_CMP_EN
    .PASS(pass_c),
`endif
    .dbg_state_o(dbg_c)
  );

  // ---------------- reference model ----------------
  // Signature after n samples = seed*x^n + sum d_k*x^(n-1-k), reduced mod P(x).
  int           m_state;     // 0 idle, 1 run, 2 done
  logic [W-1:0] samp_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held_sig;
  logic         prev_done;
  int           n_cmp;
  int           n_bad;

  function automatic logic [W-1:0] gf_mulx(input logic [W-1:0] a);
    logic [W:0] t;
    t = {a, 1'b0};
    if (t[W]) t = t ^ {1'b1, POLY_M};
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      r = gf_mulx(r);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] gf_xpow(input int e);
    logic [W-1:0] r;
    r = 24'h000001;
    for (int i = 0; i < e; i++) r = gf_mulx(r);
    return r;
  endfunction

  function automatic logic [W-1:0] ref_sig(input logic [W-1:0] seed);
    logic [W-1:0] acc;
    int n;
    n   = samp_q.size();
    acc = gf_mul(seed, gf_xpow(n));
    for (int k = 0; k < n; k++) acc = acc ^ gf_mul(samp_q[k], gf_xpow(n - 1 - k));
    return acc;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic vl, input logic [W-1:0] d);
    start = st;
    valid = vl;
    din   = d;
    @(posedge CK);
    if (m_state != 1) begin
      if (st) begin
        m_state = 1;
        samp_q.delete();
      end
    end else if (vl) begin
      samp_q.push_back(d);
      if (samp_q.size() == WIN_A) begin
        m_state = 2;
        exp_q.push_back(ref_sig(SEED_A));
      end
    end
    @(negedge CK);
  endtask

  task automatic drive2(input logic st, input logic vl, input logic [W-1:0] d);
    s2_start = st;
    s2_valid = vl;
    s2_din   = d;
    @(posedge CK);
    @(negedge CK);
  endtask

  task automatic async_reset();
    #2;
    RN = 1'b0;
    #1;
    check("rst_busy", W'(busy_a), '0);
    check("rst_done", W'(done_a), '0);
    check("rst_sig", sig_a, SEED_A);
    m_state = 0;
    samp_q.delete();
    @(negedge CK);
    RN = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CK) begin
    check("busy", W'(busy_a), W'(m_state == 1));
    check("done", W'(done_a), W'(m_state == 2));
    if (done_a && !prev_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sig_unexpected: DONE rose with no expected signature, got %h", sig_a);
      end else begin
        held_sig = exp_q.pop_front();
`ifdef S641_MISR_CMP_EN
        check("pass", W'(pass_a), W'(held_sig == GOLD_A));
`endif
      end
    end
    if (m_state == 2) begin
      check("sig_done", sig_a, held_sig);
    end else begin
      check("sig_run", sig_a, ref_sig(SEED_A));
`ifdef S641_MISR_CMP_EN
      check("pass_clr", W'(pass_a), '0);
`endif
    end
    prev_done = done_a;
  end

  // ---------------- stimulus ----------------
  initial begin
    int pat[7];
    n_cmp     = 0;
    n_bad     = 0;
    m_state   = 0;
    held_sig  = '0;
    prev_done = 1'b0;
    RN        = 1'b0;
    start = 1'b0; valid = 1'b0; din = '0;
    s2_start = 1'b0; s2_valid = 1'b0; s2_din = '0;
    repeat (2) @(negedge CK);
    check("reset_sig_b", sig_b, 24'h000000);
    check("reset_sig_c", sig_c, 24'h800000);
    RN = 1'b1;
    @(negedge CK);

    // T1: seed 1, zero data, four samples.
    drive(1'b1, 1'b0, '0);
    repeat (WIN_A) drive(1'b0, 1'b1, '0);
    check("t1_sig", sig_a, 24'h000010);
    check("t1_done", W'(done_a), 24'h1);
    check("t1_busy", W'(busy_a), '0);

    // T2: single-sample windows, plain absorb and feedback path, START+VALID reseed.
    drive2(1'b1, 1'b0, '0);
    drive2(1'b0, 1'b1, 24'h000001);
    check("t2_w1_sig", sig_b, 24'h000001);
    check("t2_w8_sig", sig_c, 24'hC20000);
    check("t2_w1_done", W'(done_b), 24'h1);
    drive2(1'b1, 1'b1, 24'h000005);
    check("t2_reseed_b", sig_b, 24'h000000);
    check("t2_reseed_c", sig_c, 24'h800000);
    check("t2_busy", W'(busy_c), 24'h1);
    drive2(1'b0, 1'b1, '0);
    check("t2_fb_sig", sig_c, 24'hC20001);
    check("t2_fb_done", W'(done_c), 24'h1);
    drive2(1'b0, 1'b0, '0);

    // T3: gapped VALID pattern, DONE only after the seventh cycle.
    pat = '{1, 0, 0, 1, 1, 0, 1};
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) begin
      check("t3_not_done", W'(done_a), '0);
      drive(1'b0, pat[i] != 0, W'($urandom));
    end
    check("t3_done", W'(done_a), 24'h1);

    // T5: START in RUN ignored; START+VALID in DONE reseeds without absorbing.
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, W'($urandom));
    drive(1'b1, 1'b1, W'($urandom));
    drive(1'b0, 1'b0, W'($urandom));
    drive(1'b0, 1'b1, W'($urandom));
    drive(1'b0, 1'b1, W'($urandom));
    drive(1'b1, 1'b1, W'($urandom));
    check("t5_reseed", sig_a, SEED_A);
    repeat (WIN_A) drive(1'b0, 1'b1, W'($urandom));

    // T4: asynchronous reset mid-run.
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, W'($urandom));
    drive(1'b0, 1'b1, W'($urandom));
    async_reset();
    @(negedge CK);

    // Randomised traffic with one more reset in the middle.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, W'($urandom));
      if (i == 200) async_reset();
    end
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);

    check("exp_q_empty", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
